// File: rtl/asm_pkg.sv
// Shared definitions for the ASM controller / datapath pair.
// Holds the status word width and encodings that the datapath returns to
// the controller, and the controller state codes.
package asm_pkg;

    localparam int STATUS_W = 32;

    localparam logic [STATUS_W-1:0] STATUS_TRUE  = 32'd1;
    localparam logic [STATUS_W-1:0] STATUS_FALSE = 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd1,
        ST_LOOP = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/datapath_unit_if.sv
// Job/strobe/status bundle between the controller side and datapath_unit.
//   start_valid/start_ready : job handshake, a_in/b_in captured on accept
//   Enable3/Enable6/Enable7 : init / iterate / finish strobes
//   output2/output5         : pending / loop-finished status words
//   result/done/overflow    : product, one-cycle completion pulse, carry flag
// master = controller/requester side, slave = datapath side.
interface datapath_unit_if #(
    parameter int WIDTH    = 16,
    parameter int STATUS_W = asm_pkg::STATUS_W
);
    logic                  start_valid;
    logic                  start_ready;
    logic [WIDTH-1:0]      a_in;
    logic [WIDTH-1:0]      b_in;
    logic                  Enable3;
    logic                  Enable6;
    logic                  Enable7;
    logic [STATUS_W-1:0]   output2;
    logic [STATUS_W-1:0]   output5;
    logic [2*WIDTH-1:0]    result;
    logic                  done;
    logic                  overflow;

    modport master (
        output start_valid, a_in, b_in, Enable3, Enable6, Enable7,
        input  start_ready, output2, output5, result, done, overflow
    );

    modport slave (
        input  start_valid, a_in, b_in, Enable3, Enable6, Enable7,
        output start_ready, output2, output5, result, done, overflow
    );
endinterface

// File: rtl/datapath_unit_mul_accum.sv
// Repeated-addition accumulator for datapath_unit.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   init      : clear acc and cnt
//   clr_ovf   : also clear the sticky carry flag (qualified with init)
//   step      : add a to acc and bump cnt, unless cnt already equals b
//   a, b      : multiplicand and iteration count
//   acc       : running sum (2*WIDTH bits)
//   eq        : cnt == b
//   ovf       : sticky carry out of acc
module mul_accum #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               clr_ovf,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               eq,
    output logic               ovf
);
    logic [WIDTH-1:0]   cnt;
    logic [2*WIDTH:0]   sum;

    // One extra bit on the adder exposes the carry out of acc.
    assign sum = {1'b0, acc} + {{(WIDTH+1){1'b0}}, a};
    assign eq  = (cnt == b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (init) begin
            acc <= '0;
            cnt <= '0;
            if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end else if (step && !eq) begin
            // Holding at cnt == b keeps the counter from ever wrapping.
            acc <= sum[2*WIDTH-1:0];
            cnt <= cnt + 1'b1;
            ovf <= ovf | sum[2*WIDTH];
        end
    end
endmodule

// File: rtl/datapath_unit.sv
// Datapath partner of the ASM control_unit: multiplies A*B by repeated
// addition under control of the controller's strobes.
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   bus      : datapath_unit_if slave -- job handshake (start_valid/
//              start_ready, a_in, b_in), strobes Enable3 (init), Enable6
//              (iterate), Enable7 (finish), status words output2 (pending)
//              and output5 (loop finished), result/done/overflow.
module datapath_unit #(
    parameter int WIDTH    = 16,
    parameter int STATUS_W = asm_pkg::STATUS_W
) (
    input  logic           clk,
    input  logic           rst,
    datapath_unit_if.slave bus
);
    import asm_pkg::*;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] result_r;
    logic               pending;
    logic               busy;
    logic               ovf;
    logic               overflow_r;
    logic               done_r;
    logic               eq;
    logic               accept;
    logic               clr_ovf;
    logic               finish;
    logic               step;

    // Strobe priority Enable3 > Enable7 > Enable6; all but the acc/cnt
    // clear of Enable3 are ignored while no job is in flight.
    assign accept  = bus.start_valid && !busy;
    assign clr_ovf = bus.Enable3 && busy;
    assign finish  = busy && !bus.Enable3 && bus.Enable7;
    assign step    = busy && !bus.Enable3 && !bus.Enable7 && bus.Enable6;

    mul_accum #(.WIDTH(WIDTH)) u_mul_accum (
        .clk     (clk),
        .rst     (rst),
        .init    (bus.Enable3),
        .clr_ovf (clr_ovf),
        .step    (step),
        .a       (a_r),
        .b       (b_r),
        .acc     (acc),
        .eq      (eq),
        .ovf     (ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_r        <= '0;
            b_r        <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            result_r   <= '0;
        end else begin
            done_r <= finish;
            if (accept) begin
                a_r     <= bus.a_in;
                b_r     <= bus.b_in;
                pending <= 1'b1;
                busy    <= 1'b1;
            end else begin
                if (clr_ovf) begin
                    pending <= 1'b0;
                end
                if (finish) begin
                    busy       <= 1'b0;
                    result_r   <= acc;
                    overflow_r <= ovf;
                end
            end
        end
    end

    assign bus.start_ready = !busy;
    assign bus.result      = result_r;
    assign bus.done        = done_r;
    assign bus.overflow    = overflow_r;

    // Loop status is masked until init has consumed the pending job, so the
    // stale cnt == b_r of an idle block never reads as "finished".
    assign bus.output2 = pending ? STATUS_W'(STATUS_TRUE) : STATUS_W'(STATUS_FALSE);
    assign bus.output5 = (busy && !pending && eq) ? STATUS_W'(STATUS_TRUE)
                                                  : STATUS_W'(STATUS_FALSE);
endmodule
